// File: rtl/trim_rx.sv
// Trim serial link receiver: sync ENCLK/DIN, shift LSB first, close frame on idle gap.
// Optional odd parity bit appended to each frame when TRIM_RX_PARITY_EN is defined.
module trim_rx #(
    parameter int WIDTH      = 12,
    parameter int GAP_CYCLES = 37500000,
    parameter int GAP_W      = 26
) (
    input  logic             CLK50,
    input  logic             RST,
    input  logic             ENCLK,
    input  logic             DIN,
    output logic [WIDTH-1:0] TRIM_CODE,
    output logic             VALID,
    output logic             ERR,
    output logic             BUSY,
    output logic [7:0]       FRAME_CNT
);

`ifdef TRIM_RX_PARITY_EN
    localparam int N = WIDTH + 1;
`else
    localparam int N = WIDTH;
`endif
    localparam int CW = $clog2(N + 2);
    localparam logic [CW-1:0] N_C = CW'(N);
    localparam logic [CW-1:0] N_SAT = CW'(N + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic {IDLE, RECV} state_t;

    state_t           state, state_n;
    logic             enclk_s1, enclk_s2, enclk_prev;
    logic             din_s1, din_s2;
    logic             rise, eval, chk_ok, good, bad;
    logic [N-1:0]     shift_q;
    logic [CW-1:0]    bit_cnt;
    logic [GAP_W-1:0] gap_q;

    always_ff @(posedge CLK50 or posedge RST) begin
        if (RST) begin
            enclk_s1   <= 1'b0;
            enclk_s2   <= 1'b0;
            enclk_prev <= 1'b0;
            din_s1     <= 1'b0;
            din_s2     <= 1'b0;
        end else begin
            enclk_s1   <= ENCLK;
            enclk_s2   <= enclk_s1;
            enclk_prev <= enclk_s2;
            din_s1     <= DIN;
            din_s2     <= din_s1;
        end
    end

    assign rise = enclk_s2 & ~enclk_prev;

`ifdef TRIM_RX_PARITY_EN
    assign chk_ok = ^shift_q;
`else
    assign chk_ok = 1'b1;
`endif

    always_ff @(posedge CLK50 or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_n;
    end

    // a rise on the expiry cycle keeps the frame open
    always_comb begin
        state_n = state;
        eval    = 1'b0;
        unique case (state)
            IDLE: if (rise) state_n = RECV;
            RECV: begin
                if (!rise && gap_q == GAP_LAST) begin
                    eval    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign good = eval && (bit_cnt == N_C) && chk_ok;
    assign bad  = eval && !good;
    assign BUSY = (state == RECV);

    always_ff @(posedge CLK50 or posedge RST) begin
        if (RST) begin
            shift_q <= '0;
            bit_cnt <= '0;
            gap_q   <= '0;
        end else if (rise) begin
            shift_q <= {din_s2, shift_q[N-1:1]};
            bit_cnt <= (bit_cnt == N_SAT) ? N_SAT : bit_cnt + 1'b1;
            gap_q   <= '0;
        end else if (eval) begin
            bit_cnt <= '0;
            gap_q   <= '0;
        end else if (state == RECV) begin
            gap_q   <= gap_q + 1'b1;
        end
    end

    always_ff @(posedge CLK50 or posedge RST) begin
        if (RST) begin
            TRIM_CODE <= '0;
            VALID     <= 1'b0;
            ERR       <= 1'b0;
            FRAME_CNT <= '0;
        end else begin
            VALID <= good;
            ERR   <= bad;
            if (good) begin
                TRIM_CODE <= shift_q[WIDTH-1:0];
                FRAME_CNT <= FRAME_CNT + 8'd1;
            end
        end
    end

endmodule
